// File: rtl/multdiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit: FSM states,
// adder operation codes and adder input-mux selects.
package multdiv_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        M_ITER = 3'd1,
        D_ABSA = 3'd2,
        D_ABSB = 3'd3,
        D_ITER = 3'd4,
        D_FIX  = 3'd5,
        DONE   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        SUB  = 2'd1,
        PASS = 2'd2,
        NEG  = 2'd3
    } add_op_t;

    typedef enum logic [1:0] {
        ASEL_ZERO = 2'd0,
        ASEL_ACC  = 2'd1,
        ASEL_REM  = 2'd2
    } a_sel_t;

    typedef enum logic [1:0] {
        BSEL_OPA  = 2'd0,
        BSEL_OPB  = 2'd1,
        BSEL_BMAG = 2'd2,
        BSEL_QUO  = 2'd3
    } b_sel_t;

endpackage

// File: rtl/csa_32.sv
// 32-bit carry-select adder: low half ripples, high half precomputed for
// both carry-ins and selected by the low-half carry.
module csa_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co,
    output logic        ovf
);
    logic [16:0] lo_sum;
    logic [16:0] hi_sum0;
    logic [16:0] hi_sum1;

    assign lo_sum  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'b0, ci};
    assign hi_sum0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    assign hi_sum1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

    assign s[15:0]         = lo_sum[15:0];
    assign {co, s[31:16]}  = lo_sum[16] ? hi_sum1 : hi_sum0;
    assign ovf             = (a[31] == b[31]) && (s[31] != a[31]);
endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiply (Booth radix-2) and restoring divide,
// sharing a single csa_32 adder; one-cycle ready pulse on completion.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter logic [31:0] DIV0_RESULT = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_reg, b_reg, bmag, rem, quo;
    logic [64:0]      prod;
    logic             div0;

    a_sel_t      a_sel;
    b_sel_t      b_sel;
    add_op_t     add_op;
    logic [31:0] a_src, b_src, add_a, add_b, sum;
    logic        add_ci, add_co, add_ovf;
    logic [31:0] rem_sh, quo_sh;
    logic        acc_sign;
    logic [64:0] prod_next;
    logic [32:0] prod_top;
    logic        last_iter;

    assign rem_sh    = {rem[30:0], quo[31]};
    assign quo_sh    = {quo[30:0], 1'b0};
    assign last_iter = (cnt == CNT_W'(ITER - 1));

    always_comb begin
        a_sel  = ASEL_ZERO;
        b_sel  = BSEL_OPA;
        add_op = PASS;
        unique case (state)
            M_ITER: begin
                a_sel = ASEL_ACC;
                case (prod[1:0])
                    2'b01:   add_op = ADD;
                    2'b10:   add_op = SUB;
                    default: add_op = PASS;
                endcase
            end
            D_ABSA: add_op = NEG;
            D_ABSB: begin
                b_sel  = BSEL_OPB;
                add_op = NEG;
            end
            D_ITER: begin
                a_sel  = ASEL_REM;
                b_sel  = BSEL_BMAG;
                add_op = SUB;
            end
            D_FIX: begin
                b_sel  = BSEL_QUO;
                add_op = NEG;
            end
            default: ;
        endcase

        case (a_sel)
            ASEL_ACC: a_src = prod[64:33];
            ASEL_REM: a_src = rem_sh;
            default:  a_src = 32'h0;
        endcase
        case (b_sel)
            BSEL_OPA:  b_src = a_reg;
            BSEL_OPB:  b_src = b_reg;
            BSEL_BMAG: b_src = bmag;
            default:   b_src = quo;
        endcase

        add_a  = a_src;
        add_b  = 32'h0;
        add_ci = 1'b0;
        case (add_op)
            ADD: add_b = b_src;
            SUB: begin
                add_b  = ~b_src;
                add_ci = 1'b1;
            end
            NEG: begin
                add_a  = 32'h0;
                add_b  = ~b_src;
                add_ci = 1'b1;
            end
            default: ;
        endcase
    end

    csa_32 u_add (
        .a   (add_a),
        .b   (add_b),
        .ci  (add_ci),
        .s   (sum),
        .co  (add_co),
        .ovf (add_ovf)
    );

    // The accumulator sum can need 33 bits; its true sign is s[31]^ovf, and
    // shifting that in keeps the upper product half exact for the overflow test.
    assign acc_sign  = sum[31] ^ add_ovf;
    assign prod_next = {acc_sign, sum, prod[32:1]};
    assign prod_top  = prod_next[64:32];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            bmag           <= '0;
            rem            <= '0;
            quo            <= '0;
            prod           <= '0;
            div0           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT) begin
                a_reg <= data_operandA;
                b_reg <= data_operandB;
                prod  <= {32'h0, data_operandB, 1'b0};
                cnt   <= '0;
                div0  <= 1'b0;
                state <= M_ITER;
            end else if (ctrl_DIV) begin
                a_reg <= data_operandA;
                b_reg <= data_operandB;
                cnt   <= '0;
                // Divide-by-zero takes the fix-up slot so it completes two cycles later.
                div0  <= (data_operandB == 32'h0);
                state <= (data_operandB == 32'h0) ? D_FIX : D_ABSA;
            end else begin
                unique case (state)
                    M_ITER: begin
                        prod <= prod_next;
                        cnt  <= cnt + 1'b1;
                        if (last_iter) begin
                            data_result    <= prod_next[32:1];
                            data_exception <= !((&prod_top) || !(|prod_top));
                            state          <= DONE;
                        end
                    end
                    D_ABSA: begin
                        quo   <= a_reg[31] ? sum : a_reg;
                        rem   <= '0;
                        state <= D_ABSB;
                    end
                    D_ABSB: begin
                        bmag  <= b_reg[31] ? sum : b_reg;
                        cnt   <= '0;
                        state <= D_ITER;
                    end
                    D_ITER: begin
                        cnt <= cnt + 1'b1;
                        if (add_co) begin
                            rem <= sum;
                            quo <= {quo_sh[31:1], 1'b1};
                        end else begin
                            rem <= rem_sh;
                            quo <= quo_sh;
                        end
                        if (last_iter)
                            state <= D_FIX;
                    end
                    D_FIX: begin
                        if (div0) begin
                            data_result    <= DIV0_RESULT;
                            data_exception <= 1'b1;
                        end else begin
                            data_result    <= (a_reg[31] ^ b_reg[31]) ? sum : quo;
                            data_exception <= (a_reg == 32'h8000_0000) && (b_reg == 32'hFFFF_FFFF);
                        end
                        state <= DONE;
                    end
                    DONE: begin
                        data_resultRDY <= 1'b1;
                        state          <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multdiv_seq.sv
// Bench for multdiv_seq: arithmetic reference model with latency bookkeeping,
// directed cases with literal expectations, then randomized ops with aborts.
module tb_multdiv_seq;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'h0;
    logic [31:0] data_operandB = 32'h0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    always #5 clock = ~clock;

    multdiv_seq dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    int vectors = 0;
    int miscompares = 0;
    int tmo_count = 0;
    int tmo_seen = 0;

    // reference model state (written only by the model process)
    int          edge_n = 0;
    int          due = 0;
    int          p_lat = 0;
    logic        pend = 1'b0;
    logic        exp_rdy = 1'b0;
    logic [31:0] pend_res = 32'h0;
    logic        pend_exc = 1'b0;
    logic [31:0] held_res = 32'h0;
    logic        held_exc = 1'b0;
    logic        p_lit = 1'b0;
    logic [31:0] p_lit_res = 32'h0;
    logic        p_lit_exc = 1'b0;
    int          p_lit_lat = 0;

    // literal expectations armed by the directed driver
    logic        lit_on = 1'b0;
    logic [31:0] lit_res = 32'h0;
    logic        lit_exc = 1'b0;
    int          lit_lat = 0;

    function automatic void model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        longint p;
        int     q;
        if (m) begin
            p   = longint'(signed'(a)) * longint'(signed'(b));
            r   = p[31:0];
            e   = (p != longint'(signed'(p[31:0])));
            lat = 33;
        end else if (b == 32'h0) begin
            r   = 32'h0;
            e   = 1'b1;
            lat = 2;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r   = 32'h8000_0000;
            e   = 1'b1;
            lat = 36;
        end else begin
            q   = signed'(a) / signed'(b);
            r   = q;
            e   = 1'b0;
            lat = 36;
        end
    endfunction

    always @(posedge clock or negedge reset_n) begin
        logic [31:0] r;
        logic        e;
        int          lat;
        if (!reset_n) begin
            pend     = 1'b0;
            exp_rdy  = 1'b0;
            held_res = 32'h0;
            held_exc = 1'b0;
        end else begin
            edge_n++;
            exp_rdy = 1'b0;
            if (ctrl_MULT || ctrl_DIV) begin
                model(ctrl_MULT, data_operandA, data_operandB, r, e, lat);
                pend      = 1'b1;
                pend_res  = r;
                pend_exc  = e;
                due       = edge_n + lat;
                p_lat     = lat;
                p_lit     = lit_on;
                p_lit_res = lit_res;
                p_lit_exc = lit_exc;
                p_lit_lat = lit_lat;
            end else if (pend && edge_n == due) begin
                exp_rdy  = 1'b1;
                pend     = 1'b0;
                held_res = pend_res;
                held_exc = pend_exc;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_n, act, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %b expected %b", nm, edge_n, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (tmo_count != tmo_seen) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_rdy at edge %0d: %0d wait(s) expired, expected 0", edge_n, tmo_count - tmo_seen);
            tmo_seen = tmo_count;
        end
        if (!reset_n) begin
            chk_bit("reset_rdy", data_resultRDY, 1'b0);
            chk("reset_result", data_result, 32'h0);
            chk_bit("reset_exc", data_exception, 1'b0);
        end else if (exp_rdy) begin
            chk_bit("rdy_pulse", data_resultRDY, 1'b1);
            chk("result", data_result, held_res);
            chk_bit("exception", data_exception, held_exc);
            if (p_lit) begin
                chk("lit_result", data_result, p_lit_res);
                chk_bit("lit_exc", data_exception, p_lit_exc);
                chk("lit_latency", 32'(p_lat), 32'(p_lit_lat));
            end
        end else begin
            chk_bit("rdy_idle", data_resultRDY, 1'b0);
            if (!pend) begin
                chk("hold_result", data_result, held_res);
                chk_bit("hold_exc", data_exception, held_exc);
            end
        end
    end

    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        lit_on    = 1'b0;
    endtask

    task automatic wait_rdy(input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clock);
            if (data_resultRDY) got = 1'b1;
        end
        if (!got) tmo_count++;
    endtask

    task automatic run_dir(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic exc, input int lat);
        lit_on  = 1'b1;
        lit_res = res;
        lit_exc = exc;
        lit_lat = lat;
        start_op(m, d, a, b);
        wait_rdy(lat + 5);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] sp [4];
        int          v;
        sp[0] = 32'h8000_0000;
        sp[1] = 32'hFFFF_FFFF;
        sp[2] = 32'h7FFF_FFFF;
        sp[3] = 32'h0000_0001;
        case ($urandom_range(0, 7))
            0, 1, 2: return $urandom;
            3, 4: begin
                v = int'($urandom_range(0, 2000)) - 1000;
                return v;
            end
            5: return $urandom >> $urandom_range(1, 31);
            6: return sp[$urandom_range(0, 3)];
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic        m, d;
        logic [31:0] a, b;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;

        run_dir(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
        run_dir(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33);
        run_dir(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 36);
        run_dir(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 36);
        run_dir(1'b0, 1'b1, 32'd5, 32'd0, 32'h0000_0000, 1'b1, 2);
        run_dir(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 36);
        run_dir(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 33);

        // MULT aborted by a DIV sampled ten edges later
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (8) @(negedge clock);
        run_dir(1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 36);

        // reset asserted just before edge 20 of a divide
        start_op(1'b0, 1'b1, 32'd123456, 32'd789);
        repeat (19) @(negedge clock);
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        repeat (45) @(negedge clock);

        run_dir(1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0, 33);
        repeat (40) @(negedge clock);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: begin m = 1'b1; d = 1'b0; end
                1: begin m = 1'b0; d = 1'b1; end
                2: begin m = 1'b1; d = 1'b1; end
                default: begin m = 1'b0; d = 1'b1; end
            endcase
            a = rnd_op();
            b = rnd_op();
            start_op(m, d, a, b);
            if ($urandom_range(0, 4) == 0)
                repeat ($urandom_range(0, 37)) @(negedge clock);
            else
                wait_rdy(40);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        repeat (40) @(negedge clock);
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
